abs_diff_approx_sched: RTL and testbench

- Shares one combinational approximate |a-b| unit (2-bit operands, SOP-synthesised, error threshold ET) among NUM_REQ requesters using round-robin arbitration.
- Each issued operation is also computed exactly in-block, and its error distance is checked.
- Accumulated error is tracked against a budget. When the budget is exceeded, the block runs in exact mode for EXACT_HOLD transactions, then returns to approximate mode.
- The block sits between operand producers and the shared approximate datapath.

---
 rtl/abs_diff_sched_pkg.sv | 25 ++
 rtl/abs_diff_approx_sched_rr_arbiter.sv | 31 +++
 rtl/abs_diff_approx_sched.sv | 122 ++++++++++++
 tb/tb_abs_diff_approx_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/abs_diff_sched_pkg.sv
// Shared types and arithmetic helpers for the approximate |a-b| scheduler.
// Helpers work on 8-bit values; callers zero-extend narrower operands.
package abs_diff_sched_pkg;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] abs_sub(input logic [7:0] x, input logic [7:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] x, input logic [7:0] d);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, d};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return sat_add(x, 8'd1);
  endfunction

endpackage

// File: rtl/abs_diff_approx_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after i_ptr, wrapping.
// Purely combinational; the owner advances the pointer.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(i_ptr) + k) % N;
      if (i_en && !found && i_req[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        o_idx        = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/abs_diff_approx_sched.sv
// Shares one approximate |a-b| unit among requesters, checks each result against
// the exact value and falls back to exact results for a while when error piles up.
module abs_diff_approx_sched
  import abs_diff_sched_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int OP_W       = 2,
  parameter int ET         = 3,
  parameter int ERR_BUDGET = 8,
  parameter int EXACT_HOLD = 4,
  localparam int ID_W      = id_width(NUM_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [NUM_REQ*OP_W-1:0] i_req_a,
  input  logic [NUM_REQ*OP_W-1:0] i_req_b,
  output logic [2*OP_W-1:0]       o_ax_in,
  input  logic [OP_W-1:0]         i_ax_out,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic [OP_W-1:0]         o_rsp_data,
  output logic [OP_W-1:0]         o_rsp_err,
  output logic                    o_rsp_exact,
  output logic [7:0]              o_stat_viol,
  output logic                    o_stat_mode
);

  state_t r_state, w_next;

  logic [ID_W-1:0]    r_ptr, r_id, w_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic [2*OP_W-1:0]  r_ax_in;
  logic [OP_W-1:0]    r_rsp_data, r_rsp_err;
  logic               r_rsp_exact, r_mode;
  logic [7:0]         r_viol, r_err_acc, r_hold;
  logic [7:0]         w_exact8, w_err8;
  logic               w_hs;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .i_en    (r_state == IDLE),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // r_ax_in doubles as the operand latch: {b,a} of the granted requester.
  assign w_exact8 = abs_sub(8'(r_ax_in[OP_W-1:0]), 8'(r_ax_in[2*OP_W-1:OP_W]));
  assign w_err8   = abs_sub(8'(i_ax_out), w_exact8);
  assign w_hs     = (r_state == RESP) && i_rsp_ready;

  assign o_ax_in     = r_ax_in;
  assign o_rsp_id    = r_id;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_exact = r_rsp_exact;
  assign o_stat_viol = r_viol;
  assign o_stat_mode = r_mode;

  always_comb begin
    w_next      = r_state;
    o_req_ready = i_rst_n ? w_grant : '0;
    o_rsp_valid = (r_state == RESP);
    case (r_state)
      IDLE:    if (|w_grant) w_next = CALC;
      CALC:    w_next = RESP;
      RESP:    if (i_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_ax_in     <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= '0;
      r_rsp_exact <= 1'b0;
      r_mode      <= 1'b0;
      r_viol      <= '0;
      r_err_acc   <= '0;
      r_hold      <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && (|w_grant)) begin
        r_ax_in <= {i_req_b[w_idx*OP_W +: OP_W], i_req_a[w_idx*OP_W +: OP_W]};
        r_id    <= w_idx;
        r_ptr   <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
      end
      if (r_state == CALC) begin
        if (r_mode) begin
          r_rsp_data  <= w_exact8[OP_W-1:0];
          r_rsp_err   <= '0;
          r_rsp_exact <= 1'b1;
        end else begin
          r_rsp_data  <= i_ax_out;
          r_rsp_err   <= w_err8[OP_W-1:0];
          r_rsp_exact <= 1'b0;
          r_err_acc   <= sat_add(r_err_acc, w_err8);
          if (w_err8 > 8'(ET)) r_viol <= sat_inc(r_viol);
        end
      end
      // Mode changes only at a handshake, so the next issued op sees the new mode.
      if (w_hs) begin
        if (!r_mode && (r_err_acc > 8'(ERR_BUDGET))) begin
          r_mode    <= 1'b1;
          r_hold    <= 8'(EXACT_HOLD);
          r_err_acc <= '0;
        end else if (r_mode) begin
          r_hold <= r_hold - 8'd1;
          if (r_hold == 8'd1) r_mode <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_abs_diff_approx_sched.sv
// Randomised self-checking bench for abs_diff_approx_sched with a transaction-level model.
// Two instances differ only in ET (3 and 2) so that violation counting is exercised.
module tb_abs_diff_approx_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [3:0] req_a, req_b;
  logic       rsp_ready;

  logic [1:0] a_req_ready, b_req_ready;
  logic [3:0] a_ax_in, b_ax_in;
  logic [1:0] a_ax_out, b_ax_out;
  logic       a_rsp_valid, b_rsp_valid;
  logic       a_rsp_id, b_rsp_id;
  logic [1:0] a_rsp_data, b_rsp_data, a_rsp_err, b_rsp_err;
  logic       a_rsp_exact, b_rsp_exact;
  logic [7:0] a_stat_viol, b_stat_viol;
  logic       a_stat_mode, b_stat_mode;

  // Behavioural stand-in for the approximate unit: a lookup table indexed by {b,a}.
  logic [1:0] lut [16];
  assign a_ax_out = lut[a_ax_in];
  assign b_ax_out = lut[b_ax_in];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_ptr, m_acc, m_mode, m_hold, m_viol_a, m_viol_b;

  always #5 clk = ~clk;

  abs_diff_approx_sched #(.NUM_REQ(2), .OP_W(2), .ET(3), .ERR_BUDGET(8), .EXACT_HOLD(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(a_req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .o_ax_in(a_ax_in), .i_ax_out(a_ax_out),
    .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(a_rsp_id),
    .o_rsp_data(a_rsp_data), .o_rsp_err(a_rsp_err), .o_rsp_exact(a_rsp_exact),
    .o_stat_viol(a_stat_viol), .o_stat_mode(a_stat_mode)
  );

  abs_diff_approx_sched #(.NUM_REQ(2), .OP_W(2), .ET(2), .ERR_BUDGET(8), .EXACT_HOLD(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(b_req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .o_ax_in(b_ax_in), .i_ax_out(b_ax_out),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(b_rsp_id),
    .o_rsp_data(b_rsp_data), .o_rsp_err(b_rsp_err), .o_rsp_exact(b_rsp_exact),
    .o_stat_viol(b_stat_viol), .o_stat_mode(b_stat_mode)
  );

  task automatic model_reset();
    m_ptr = 0; m_acc = 0; m_mode = 0; m_hold = 0; m_viol_a = 0; m_viol_b = 0;
  endtask

  task automatic resetDut();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One full transaction from the IDLE cycle through the handshake, checked cycle by cycle.
  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] a0, input logic [1:0] b0,
                               input logic [1:0] a1, input logic [1:0] b1, input int bp);
    int g, ex, ax, err;
    logic [1:0] a, b, exp_data, exp_err;
    logic exp_exact;
    g = -1;
    for (int k = 0; k < 2; k++)
      if (g < 0 && v[(m_ptr + k) % 2]) g = (m_ptr + k) % 2;
    a = (g == 1) ? a1 : a0;
    b = (g == 1) ? b1 : b0;
    ex = (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
    ax = int'(lut[{b, a}]);
    err = (ax > ex) ? ax - ex : ex - ax;
    exp_data  = (m_mode != 0) ? 2'(ex) : 2'(ax);
    exp_err   = (m_mode != 0) ? 2'd0 : 2'(err);
    exp_exact = (m_mode != 0);

    req_valid = v; req_a = {a1, a0}; req_b = {b1, b0}; rsp_ready = 1'b0;
    #1;
    checks++;
    if (a_req_ready !== 2'(1 << g)) begin
      errors++; $display("[TB] FAIL grant: got %b expected %b", a_req_ready, 2'(1 << g));
    end
    @(posedge clk); #1;
    req_valid = v & ~2'(1 << g);
    m_ptr = (g + 1) % 2;
    if (m_mode == 0) begin
      m_acc = (m_acc + err > 255) ? 255 : m_acc + err;
      if (err > 3 && m_viol_a < 255) m_viol_a++;
      if (err > 2 && m_viol_b < 255) m_viol_b++;
    end
    #1;
    checks++;
    if (a_ax_in !== {b, a} || a_req_ready !== 2'b00 || a_rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL calc: ax_in %h ready %b valid %b expected ax_in %h ready 00 valid 0",
                         a_ax_in, a_req_ready, a_rsp_valid, {b, a});
    end
    @(posedge clk); #1;
    for (int c = 0; c <= bp; c++) begin
      checks++;
      if (a_rsp_valid !== 1'b1 || a_rsp_id !== 1'(g) || a_rsp_data !== exp_data ||
          a_rsp_err !== exp_err || a_rsp_exact !== exp_exact || a_req_ready !== 2'b00) begin
        errors++;
        $display("[TB] FAIL resp cycle %0d: valid %b id %0d data %0d err %0d exact %b ready %b expected 1 %0d %0d %0d %b 00",
                 c, a_rsp_valid, a_rsp_id, a_rsp_data, a_rsp_err, a_rsp_exact, a_req_ready,
                 g, exp_data, exp_err, exp_exact);
      end
      checks++;
      if (b_rsp_data !== exp_data || b_rsp_exact !== exp_exact) begin
        errors++; $display("[TB] FAIL resp_b: data %0d exact %b expected %0d %b",
                           b_rsp_data, b_rsp_exact, exp_data, exp_exact);
      end
      if (c < bp) begin
        @(posedge clk); #1;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = '0;
    if (m_mode == 0 && m_acc > 8) begin
      m_mode = 1; m_hold = 4; m_acc = 0;
    end else if (m_mode != 0) begin
      m_hold--;
      if (m_hold == 0) m_mode = 0;
    end
    checks++;
    if (a_rsp_valid !== 1'b0 || a_stat_mode !== 1'(m_mode)) begin
      errors++; $display("[TB] FAIL after_hs: valid %b mode %b expected 0 %0d", a_rsp_valid, a_stat_mode, m_mode);
    end
    checks++;
    if (a_stat_viol !== 8'(m_viol_a) || b_stat_viol !== 8'(m_viol_b)) begin
      errors++; $display("[TB] FAIL stat_viol: a %0d b %0d expected %0d %0d",
                         a_stat_viol, b_stat_viol, m_viol_a, m_viol_b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    req_a = 4'($urandom); req_b = 4'($urandom);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_req_ready, a_ax_in, a_rsp_valid, a_rsp_id, a_rsp_data, a_rsp_err, a_rsp_exact,
         a_stat_viol, a_stat_mode} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs: got ready %b ax %h valid %b id %b data %0d err %0d exact %b viol %0d mode %b expected all 0",
                         a_req_ready, a_ax_in, a_rsp_valid, a_rsp_id, a_rsp_data, a_rsp_err,
                         a_rsp_exact, a_stat_viol, a_stat_mode);
    end
    resetDut();
  endtask

  task automatic test_single();
    lut[{2'd1, 2'd3}] = 2'd2;
    applyStimulus(2'b01, 2'd3, 2'd1, 2'd0, 2'd0, 0);
  endtask

  task automatic test_idle();
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (a_req_ready !== 2'b00 || a_rsp_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL idle: ready %b valid %b expected 00 0", a_req_ready, a_rsp_valid);
      end
    end
  endtask

  task automatic test_contention();
    resetDut();
    for (int t = 0; t < 4; t++)
      applyStimulus(2'b11, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 0);
  endtask

  task automatic test_violation();
    resetDut();
    lut[0] = 2'd3;
    applyStimulus(2'b01, 2'd0, 2'd0, 2'd0, 2'd0, 0);
  endtask

  task automatic test_budget();
    resetDut();
    lut[0] = 2'd3;
    for (int t = 0; t < 3; t++) applyStimulus(2'b01, 2'd0, 2'd0, 2'd0, 2'd0, 0);
    checks++;
    if (a_stat_mode !== 1'b1) begin
      errors++; $display("[TB] FAIL budget_enter: mode %b expected 1", a_stat_mode);
    end
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) lut[i] = 2'($urandom);
      applyStimulus(2'b11, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 0);
    end
    checks++;
    if (a_stat_mode !== 1'b0) begin
      errors++; $display("[TB] FAIL budget_exit: mode %b expected 0", a_stat_mode);
    end
  endtask

  task automatic test_backpressure();
    applyStimulus(2'b11, 2'd2, 2'd1, 2'd3, 2'd0, 5);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 16; i++) lut[i] = 2'($urandom);
      applyStimulus(2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom), 2'($urandom),
                    2'($urandom), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) test_idle();
    end
  endtask

  task automatic test_reset_mid_calc();
    resetDut();
    applyStimulus(2'b01, 2'd1, 2'd2, 2'd0, 2'd0, 0);
    req_valid = 2'b10; req_a = 4'b0100; req_b = 4'b0000; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({a_req_ready, a_ax_in, a_rsp_valid, a_rsp_id, a_rsp_data, a_rsp_err, a_rsp_exact,
         a_stat_viol, a_stat_mode} !== '0) begin
      errors++; $display("[TB] FAIL abort_outputs: ax %h valid %b id %b data %0d mode %b expected all 0",
                         a_ax_in, a_rsp_valid, a_rsp_id, a_rsp_data, a_stat_mode);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (a_rsp_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL abort_no_rsp: valid %b expected 0", a_rsp_valid);
      end
    end
    rsp_ready = 1'b0;
    model_reset();
    applyStimulus(2'b11, 2'd3, 2'd3, 2'd1, 2'd0, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) lut[i] = 2'd0;
    model_reset();
    test_reset();
    test_single();
    test_idle();
    test_contention();
    test_violation();
    test_budget();
    test_backpressure();
    test_random();
    test_reset_mid_calc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
